// File: rtl/gpio_port.sv
// gpio_port: register-mapped GPIO with direction/output control, atomic set/clear,
// synchronised and debounced inputs, and edge-triggered interrupt pending bits.
module gpio_port #(
    parameter int NPIN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      waddr_i,
    input  logic [31:0]     data_i,
    input  logic [3:0]      sel_i,
    input  logic            we_i,
    input  logic [7:0]      raddr_i,
    input  logic            rd_i,
    output logic [31:0]     data_o,
    input  logic [NPIN-1:0] gpio_i,
    output logic [NPIN-1:0] gpio_o,
    output logic [NPIN-1:0] gpio_oe,
    output logic            irq_o
);

    localparam logic [5:0] IDX_DIR     = 6'd0;
    localparam logic [5:0] IDX_OUT     = 6'd1;
    localparam logic [5:0] IDX_IN      = 6'd2;
    localparam logic [5:0] IDX_OUT_SET = 6'd3;
    localparam logic [5:0] IDX_OUT_CLR = 6'd4;
    localparam logic [5:0] IDX_RISE_EN = 6'd5;
    localparam logic [5:0] IDX_FALL_EN = 6'd6;
    localparam logic [5:0] IDX_IP      = 6'd7;
    localparam logic [5:0] IDX_DB_CFG  = 6'd8;

    logic [NPIN-1:0] dir_q;
    logic [NPIN-1:0] out_q;
    logic [NPIN-1:0] rise_en_q;
    logic [NPIN-1:0] fall_en_q;
    logic [NPIN-1:0] ip_q;
    logic [15:0]     db_cfg_q;
    logic [15:0]     cnt_q;

    logic [NPIN-1:0] sync1_q;
    logic [NPIN-1:0] sync_q;
    logic [NPIN-1:0] smp_q;
    logic [NPIN-1:0] filt_q;
    logic [NPIN-1:0] filt_d_q;
    logic [NPIN-1:0] filt_nxt;

    logic [5:0]      widx;
    logic [5:0]      ridx;
    logic [31:0]     bmask;
    logic [NPIN-1:0] wmask;
    logic [NPIN-1:0] wdata;
    logic [NPIN-1:0] w1c;
    logic [NPIN-1:0] agree;
    logic [NPIN-1:0] rise;
    logic [NPIN-1:0] fall;
    logic [31:0]     rd_val;
    logic            tick;

    logic wr_dir;
    logic wr_out;
    logic wr_set;
    logic wr_clr;
    logic wr_rise;
    logic wr_fall;
    logic wr_ip;
    logic wr_db;

    logic unused_ok;

    assign widx  = waddr_i[7:2];
    assign ridx  = raddr_i[7:2];
    assign bmask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign wmask = bmask[NPIN-1:0];
    assign wdata = data_i[NPIN-1:0] & wmask;

    assign wr_dir  = we_i && (widx == IDX_DIR);
    assign wr_out  = we_i && (widx == IDX_OUT);
    assign wr_set  = we_i && (widx == IDX_OUT_SET);
    assign wr_clr  = we_i && (widx == IDX_OUT_CLR);
    assign wr_rise = we_i && (widx == IDX_RISE_EN);
    assign wr_fall = we_i && (widx == IDX_FALL_EN);
    assign wr_ip   = we_i && (widx == IDX_IP);
    assign wr_db   = we_i && (widx == IDX_DB_CFG);

    assign unused_ok = ^{waddr_i[1:0], raddr_i[1:0], data_i, bmask};

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign irq_o   = |ip_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            db_cfg_q  <= '0;
        end else begin
            if (wr_dir)
                dir_q <= (dir_q & ~wmask) | wdata;
            if (wr_out)
                out_q <= (out_q & ~wmask) | wdata;
            else if (wr_set)
                out_q <= out_q | wdata;
            else if (wr_clr)
                out_q <= out_q & ~wdata;
            if (wr_rise)
                rise_en_q <= (rise_en_q & ~wmask) | wdata;
            if (wr_fall)
                fall_en_q <= (fall_en_q & ~wmask) | wdata;
            if (wr_db)
                db_cfg_q <= (db_cfg_q & ~bmask[15:0]) | (data_i[15:0] & bmask[15:0]);
        end
    end

    // A change must be seen on two consecutive prescaler ticks before filt follows it.
    assign tick  = (db_cfg_q != 16'd0) && (cnt_q == db_cfg_q);
    assign agree = ~(sync_q ^ smp_q);

    always_comb begin
        filt_nxt = filt_q;
        if (db_cfg_q == 16'd0)
            filt_nxt = sync_q;
        else if (tick)
            filt_nxt = (filt_q & ~agree) | (sync_q & agree);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync_q   <= '0;
            smp_q    <= '0;
            filt_q   <= '0;
            filt_d_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= gpio_i;
            sync_q   <= sync1_q;
            filt_q   <= filt_nxt;
            filt_d_q <= filt_q;
            if (wr_db) begin
                cnt_q <= '0;
                smp_q <= sync_q;
            end else if (db_cfg_q == 16'd0) begin
                cnt_q <= '0;
            end else if (tick) begin
                cnt_q <= '0;
                smp_q <= sync_q;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    // New edges win over a coincident W1C so no event is lost.
    assign rise = filt_q & ~filt_d_q;
    assign fall = ~filt_q & filt_d_q;
    assign w1c  = wr_ip ? wdata : '0;

    always_ff @(posedge clk) begin
        if (rst)
            ip_q <= '0;
        else
            ip_q <= (ip_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_comb begin
        rd_val = '0;
        case (ridx)
            IDX_DIR:     rd_val[NPIN-1:0] = dir_q;
            IDX_OUT:     rd_val[NPIN-1:0] = out_q;
            IDX_IN:      rd_val[NPIN-1:0] = filt_q;
            IDX_RISE_EN: rd_val[NPIN-1:0] = rise_en_q;
            IDX_FALL_EN: rd_val[NPIN-1:0] = fall_en_q;
            IDX_IP:      rd_val[NPIN-1:0] = ip_q;
            IDX_DB_CFG:  rd_val[15:0]     = db_cfg_q;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            data_o <= '0;
        else if (rd_i)
            data_o <= rd_val;
    end

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: register-access vector table followed by
// hand-written sequences for input latency, W1C collision, debounce and reset.
module tb_gpio_port;

    logic        clk;
    logic        rst;
    logic [7:0]  waddr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [7:0]  raddr_i;
    logic        rd_i;
    logic [31:0] data_o;
    logic [15:0] gpio_i;
    logic [15:0] gpio_o;
    logic [15:0] gpio_oe;
    logic        irq_o;

    int total;
    int bad;

    typedef struct {
        logic        is_rd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [15:0] exp_o;
        logic [15:0] exp_oe;
    } vec_t;

    vec_t vecs[$];

    gpio_port #(.NPIN(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .waddr_i (waddr_i),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .we_i    (we_i),
        .raddr_i (raddr_i),
        .rd_i    (rd_i),
        .data_o  (data_o),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic is_rd, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [3:0] sel);
        @(negedge clk);
        if (is_rd) begin
            rd_i    = 1'b1;
            raddr_i = addr;
        end else begin
            we_i    = 1'b1;
            waddr_i = addr;
            data_i  = data;
            sel_i   = sel;
        end
        @(posedge clk);
        #1;
        we_i = 1'b0;
        rd_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input int b, input logic v);
        @(negedge clk);
        gpio_i[b] = v;
    endtask

    task automatic addVec(input logic is_rd, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input logic [31:0] exp_rd,
                          input logic [15:0] exp_o, input logic [15:0] exp_oe);
        vec_t v;
        v.is_rd  = is_rd;
        v.addr   = addr;
        v.data   = data;
        v.sel    = sel;
        v.exp_rd = exp_rd;
        v.exp_o  = exp_o;
        v.exp_oe = exp_oe;
        vecs.push_back(v);
    endtask

    initial begin
        int  at;
        bit  seen;

        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        we_i    = 1'b0;
        rd_i    = 1'b0;
        waddr_i = '0;
        raddr_i = '0;
        data_i  = '0;
        sel_i   = '0;
        gpio_i  = '0;

        // Register-access table: R = read check of data_o, W = check of gpio_o/gpio_oe
        for (int a = 0; a <= 8'h24; a += 4)
            addVec(1'b1, 8'(a), 32'h0, 4'h0, 32'h0, 16'h0, 16'h0);
        addVec(1'b0, 8'h00, 32'h0000_00FF, 4'hF, 32'h0, 16'h0000, 16'h00FF);
        addVec(1'b0, 8'h04, 32'h0000_1234, 4'hF, 32'h0, 16'h1234, 16'h00FF);
        addVec(1'b0, 8'h0C, 32'h0000_8001, 4'h1, 32'h0, 16'h1235, 16'h00FF);
        addVec(1'b0, 8'h10, 32'h0000_0004, 4'hF, 32'h0, 16'h1231, 16'h00FF);
        addVec(1'b1, 8'h04, 32'h0,         4'h0, 32'h0000_1231, 16'h0, 16'h0);
        addVec(1'b1, 8'h0C, 32'h0,         4'h0, 32'h0, 16'h0, 16'h0);
        addVec(1'b1, 8'h10, 32'h0,         4'h0, 32'h0, 16'h0, 16'h0);
        addVec(1'b0, 8'h00, 32'h1234_5678, 4'h2, 32'h0, 16'h1231, 16'h56FF);
        addVec(1'b1, 8'h00, 32'h0,         4'h0, 32'h0000_56FF, 16'h0, 16'h0);
        addVec(1'b0, 8'h00, 32'h0000_00FF, 4'hF, 32'h0, 16'h1231, 16'h00FF);
        addVec(1'b0, 8'h14, 32'hFFFF_0001, 4'hF, 32'h0, 16'h1231, 16'h00FF);
        addVec(1'b1, 8'h14, 32'h0,         4'h0, 32'h0000_0001, 16'h0, 16'h0);
        addVec(1'b0, 8'h18, 32'h0000_0008, 4'hF, 32'h0, 16'h1231, 16'h00FF);
        addVec(1'b1, 8'h18, 32'h0,         4'h0, 32'h0000_0008, 16'h0, 16'h0);
        addVec(1'b0, 8'h20, 32'hABCD_1234, 4'hF, 32'h0, 16'h1231, 16'h00FF);
        addVec(1'b1, 8'h20, 32'h0,         4'h0, 32'h0000_1234, 16'h0, 16'h0);
        addVec(1'b0, 8'h20, 32'h0000_FF00, 4'h1, 32'h0, 16'h1231, 16'h00FF);
        addVec(1'b1, 8'h20, 32'h0,         4'h0, 32'h0000_1200, 16'h0, 16'h0);
        addVec(1'b0, 8'h20, 32'h0000_0000, 4'hF, 32'h0, 16'h1231, 16'h00FF);
        addVec(1'b1, 8'h20, 32'h0,         4'h0, 32'h0, 16'h0, 16'h0);
        addVec(1'b0, 8'h24, 32'hFFFF_FFFF, 4'hF, 32'h0, 16'h1231, 16'h00FF);
        addVec(1'b1, 8'h24, 32'h0,         4'h0, 32'h0, 16'h0, 16'h0);
        addVec(1'b0, 8'h08, 32'h0000_FFFF, 4'hF, 32'h0, 16'h1231, 16'h00FF);
        addVec(1'b1, 8'h08, 32'h0,         4'h0, 32'h0, 16'h0, 16'h0);
        addVec(1'b0, 8'h04, 32'h0000_FFFF, 4'h0, 32'h0, 16'h1231, 16'h00FF);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_gpio_o", 32'(gpio_o), 32'h0);
        checkOutput("reset_gpio_oe", 32'(gpio_oe), 32'h0);
        checkOutput("reset_irq", 32'(irq_o), 32'h0);
        checkOutput("reset_data_o", data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].is_rd, vecs[i].addr, vecs[i].data, vecs[i].sel);
            if (vecs[i].is_rd) begin
                checkOutput($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), data_o, vecs[i].exp_rd);
            end else begin
                checkOutput($sformatf("vec%0d_gpio_o", i), 32'(gpio_o), 32'(vecs[i].exp_o));
                checkOutput($sformatf("vec%0d_gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
            end
        end

        // Input latency with no debounce: IN after edge 3, IP/irq after edge 4
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            if (e == 1)
                gpio_i[0] = 1'b1;
            rd_i    = (e >= 3);
            raddr_i = 8'h08;
            @(posedge clk);
            #1;
            rd_i = 1'b0;
            if (e == 3) begin
                checkOutput("in0_edge3_read", data_o, 32'h0);
                checkOutput("irq_edge3", 32'(irq_o), 32'h0);
            end
            if (e == 4) begin
                checkOutput("in0_edge4_read", data_o, 32'h1);
                checkOutput("irq_edge4", 32'(irq_o), 32'h1);
            end
        end
        applyStimulus(1'b1, 8'h1C, 32'h0, 4'h0);
        checkOutput("ip_after_rise0", data_o, 32'h1);
        applyStimulus(1'b0, 8'h1C, 32'h1, 4'hF);
        checkOutput("irq_after_w1c0", 32'(irq_o), 32'h0);

        // Falling edge on bit 3 colliding with a W1C of that bit
        driveBit(3, 1'b1);
        idle(6);
        driveBit(3, 1'b0);
        idle(6);
        applyStimulus(1'b1, 8'h1C, 32'h0, 4'h0);
        checkOutput("ip_after_fall3", data_o, 32'h8);
        driveBit(3, 1'b1);
        idle(6);
        driveBit(3, 1'b0);
        repeat (3) @(posedge clk);
        applyStimulus(1'b0, 8'h1C, 32'h8, 4'hF);
        applyStimulus(1'b1, 8'h1C, 32'h0, 4'h0);
        checkOutput("ip_w1c_collision", data_o, 32'h8);
        checkOutput("irq_w1c_collision", 32'(irq_o), 32'h1);
        applyStimulus(1'b0, 8'h1C, 32'h8, 4'hF);
        applyStimulus(1'b1, 8'h1C, 32'h0, 4'h0);
        checkOutput("ip_cleared3", data_o, 32'h0);
        checkOutput("irq_cleared3", 32'(irq_o), 32'h0);
        driveBit(3, 1'b1);
        idle(6);
        applyStimulus(1'b0, 8'h14, 32'h9, 4'hF);
        idle(2);
        applyStimulus(1'b1, 8'h1C, 32'h0, 4'h0);
        checkOutput("ip_disabled_edge_dropped", data_o, 32'h0);

        // Debounce with DB_CFG = 9: short glitch rejected, steady level accepted
        applyStimulus(1'b0, 8'h20, 32'h9, 4'hF);
        driveBit(2, 1'b1);
        repeat (5) @(posedge clk);
        driveBit(2, 1'b0);
        idle(30);
        applyStimulus(1'b1, 8'h08, 32'h0, 4'h0);
        checkOutput("db_glitch_rejected", data_o, 32'h9);
        driveBit(2, 1'b1);
        seen = 1'b0;
        at   = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            rd_i    = 1'b1;
            raddr_i = 8'h08;
            @(posedge clk);
            #1;
            rd_i = 1'b0;
            if (data_o[2]) begin
                seen = 1'b1;
                at   = c;
            end
        end
        checkOutput("db_level_seen", 32'(seen), 32'h1);
        checkOutput("db_latency_window", 32'(at >= 13 && at <= 22), 32'h1);
        applyStimulus(1'b1, 8'h08, 32'h0, 4'h0);
        checkOutput("in_upper_zero", data_o, 32'h0000_000D);

        // Same-cycle read and write of OUT returns the old value
        @(negedge clk);
        we_i    = 1'b1;
        waddr_i = 8'h04;
        data_i  = 32'h0000_AAAA;
        sel_i   = 4'hF;
        rd_i    = 1'b1;
        raddr_i = 8'h04;
        @(posedge clk);
        #1;
        we_i = 1'b0;
        rd_i = 1'b0;
        checkOutput("rw_collision_old", data_o, 32'h0000_1231);
        checkOutput("rw_collision_gpio_o", 32'(gpio_o), 32'h0000_AAAA);
        applyStimulus(1'b1, 8'h40, 32'h0, 4'h0);
        checkOutput("unmapped_40", data_o, 32'h0);
        applyStimulus(1'b1, 8'h04, 32'h0, 4'h0);
        idle(3);
        checkOutput("data_o_holds", data_o, 32'h0000_AAAA);

        // Mid-run reset clears a pending interrupt and the input path
        applyStimulus(1'b0, 8'h14, 32'h2, 4'hF);
        driveBit(1, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (irq_o)
                seen = 1'b1;
        end
        checkOutput("irq_bit1_seen", 32'(seen), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_irq", 32'(irq_o), 32'h0);
        checkOutput("midreset_gpio_o", 32'(gpio_o), 32'h0);
        checkOutput("midreset_gpio_oe", 32'(gpio_oe), 32'h0);
        checkOutput("midreset_data_o", data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 8'h08, 32'h0, 4'h0);
        checkOutput("midreset_in", data_o, 32'h0);
        applyStimulus(1'b1, 8'h20, 32'h0, 4'h0);
        checkOutput("midreset_db_cfg", data_o, 32'h0);
        applyStimulus(1'b1, 8'h1C, 32'h0, 4'h0);
        checkOutput("midreset_ip", data_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
# gpio_port

Memory-mapped general-purpose I/O peripheral occupying slot 4 of the system I/O block's 16-way peripheral decode. Uses the same register-port interface as the UART and SPI peripherals in the slots below it: decoded write strobe, 8-bit byte addresses, byte selects, and a registered read-data output. Provides per-pin direction and output control, atomic set/clear, synchronised and debounced inputs, and edge-triggered interrupt pending bits with a combined interrupt request.

## Interface
- NPIN, 16, number of pins, 1..32; register bits at index NPIN and above read 0 and ignore writes.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- waddr_i  in  8  write byte address; word index is waddr_i[7:2], and bits [1:0] are ignored.
- data_i  in  32  write data.
- sel_i  in  4  byte selects; sel_i[b] enables bits [8b+7:8b].
- we_i  in  1  write strobe; asserted for exactly one cycle per accepted write.
- raddr_i  in  8  read byte address; word index is raddr_i[7:2].
- rd_i  in  1  read strobe; asserted on the read-address handshake cycle.
- data_o  out  32  registered read data; holds its value until the next rd_i.
- gpio_i  in  NPIN  asynchronous pin inputs.
- gpio_o  out  NPIN  pin output values; equals the OUT register.
- gpio_oe  out  NPIN  pin output enables; equals the DIR register (1 = drive).
- irq_o  out  1  OR of all IP bits.

## Operation
- Register map (offset, access):
  - 0x00 DIR, RW.
  - 0x04 OUT, RW.
  - 0x08 IN, RO: the filtered input value.
  - 0x0C OUT_SET, WO: each 1 sets the matching OUT bit; reads 0.
  - 0x10 OUT_CLR, WO: each 1 clears the matching OUT bit; reads 0.
  - 0x14 RISE_EN, RW.
  - 0x18 FALL_EN, RW.
  - 0x1C IP, RW1C.
  - 0x20 DB_CFG, RW, bits [15:0] only.
- Unmapped offsets: writes are ignored and reads return 0.
- Byte selects apply to every write. A SET, CLR or W1C bit takes effect only when its byte is selected.
- Input path: each pin passes through a 2-flop synchroniser (sync), then the debounce stage (filt), then a 1-cycle delay register (filt_d).
- Debounce, DB_CFG = N:
  - N = 0: filt <= sync every cycle.
  - N > 0: a 16-bit prescaler counts 0..N and wraps. A tick occurs when cnt == N.
  - On each tick: smp <= sync, and if sync == smp then filt <= sync. A change must therefore be seen on two consecutive ticks to propagate.
  - Any write to DB_CFG zeroes cnt and reloads smp from sync.
- Edge detect: rise = filt & ~filt_d; fall = ~filt & filt_d.
- IP update per bit: IP <= (IP & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - A new edge in the same cycle as a W1C of that bit leaves the bit set.
  - Edges that occur while the enable is 0 are discarded, not latched.
- Read: on rd_i, data_o <= the register at raddr_i using its pre-edge value. A write to the same register in the same cycle is not visible to that read. When rd_i is low, data_o holds.

## Timing
- Reset values:
  - DIR, OUT, RISE_EN, FALL_EN, IP and DB_CFG reset to 0.
  - sync, smp, filt, filt_d, cnt and data_o reset to 0.
  - gpio_o = 0, gpio_oe = 0, irq_o = 0.
- Reset asserted mid-operation clears all of the above on the next edge. This includes pending interrupts and the debounce state.
- Write latency: a register write at edge k is visible on gpio_o/gpio_oe and to reads after edge k.
- Read latency is 1 cycle: data_o is valid in the cycle after rd_i. This is the cycle in which the bus wrapper presents rvalid.
- Input latency with N = 0: gpio_i stable before edge 1 gives sync after edge 2, filt and IN after edge 3, IP and irq_o after edge 4.
- Input latency with N > 0: filt updates between N+1 and 2(N+1) cycles after sync changes.
- irq_o is combinational from IP, so it rises in the same cycle as IP and falls in the cycle after the W1C that clears the last bit.
- Glitches shorter than one tick period are rejected when N > 0.

## Test plan
- Reset, then read every offset 0x00..0x24: expect 0 everywhere, with gpio_o = gpio_oe = irq_o = 0.
- Write DIR = 0x00FF and OUT = 0x1234; write OUT_SET = 0x8001 with sel = 4'b0001; write OUT_CLR = 0x0004: expect gpio_o = 0x1231 and gpio_oe = 0x00FF.
- With N = 0 and RISE_EN = 0x0001, drive gpio_i[0] from 0 to 1: expect IN bit 0 = 1 after 3 edges, then IP = 0x1 and irq_o = 1 after the 4th edge. Write IP = 0x1: expect irq_o = 0 on the next cycle.
- With FALL_EN[3] = 1, issue a W1C of IP[3] in the same cycle that a falling edge reaches filt_d: expect IP[3] to remain 1.
- With DB_CFG = 9, apply a 5-cycle high pulse on gpio_i[2]: expect IN unchanged. Hold high for 25 cycles: expect IN[2] = 1 within 20 cycles of sync changing.
- Read of 0x04 coincident with a write of 0x04 = 0xAAAA: expect data_o to return the old value. Read of unmapped 0x40: expect data_o = 0. Read of IN with NPIN = 16: expect bits [31:16] = 0.
